// File: rtl/data_mem_responder.sv
// Data-memory responder: serves scalar and vector load/store requests from the
// memory stage against a 32-bit synchronous memory with 1-cycle read latency.
// Vector accesses are split into V/N word beats inside one aligned block.
module data_mem_responder #(
    parameter int unsigned N = 32,
    parameter int unsigned V = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         MemReadM,
    input  logic         MemWriteM,
    input  logic         VecAccessM,
    input  logic [N-1:0] AddressM,
    input  logic [3:0]   ByteenaM,
    input  logic [N-1:0] WriteDataM,
    input  logic [V-1:0] WriteDataVM,
    output logic [N-1:0] ReadDataS,
    output logic [V-1:0] ReadDataV,
    output logic         Busy,
    input  logic [N-1:0] ReadData,
    output logic [N-1:0] AddressData,
    output logic [3:0]   ByteenaData,
    output logic [N-1:0] WriteData,
    output logic         RdenData,
    output logic         WrenData
);

    localparam int unsigned B     = V / N;
    localparam int unsigned LaneW = $clog2(B);
    localparam int unsigned OffW  = $clog2(V / 8);

    typedef enum logic [2:0] {StIdle, StSrd, StVrd, StVrdl, StVwr, StDone} state_e;

    state_e           state_q, state_d;
    logic [LaneW-1:0] k_q, k_d;
    logic [N-1:0]     addr_q, addr_d;
    logic [V-1:0]     wdata_q, wdata_d;
    logic [N-1:0]     rdata_s_q, rdata_s_d;
    logic [V-1:0]     rdata_v_q, rdata_v_d;

    logic [N-1:0]     req_word_addr;
    logic [N-1:0]     req_base_addr;
    logic [N-1:0]     beat_addr;
    logic [N-1:0]     wr_lane;
    logic             cap_en;
    logic [LaneW-1:0] cap_lane;
    logic             unused_addr_bits;

    assign req_word_addr    = {AddressM[N-1:2], 2'b00};
    assign req_base_addr    = {AddressM[N-1:OffW], {OffW{1'b0}}};
    // Beat index replaces the word-offset field, so beats never leave the block.
    assign beat_addr        = {addr_q[N-1:OffW], k_q, 2'b00};
    assign unused_addr_bits = ^AddressM[1:0];

    // Select the latched store lane for the current beat.
    always_comb begin
        wr_lane = '0;
        for (int i = 0; i < int'(B); i++) begin
            if (k_q == LaneW'(i)) begin
                wr_lane = wdata_q[i*N +: N];
            end
        end
    end

    // Next-state, request latching and memory-side outputs.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_s_d   = rdata_s_q;
        cap_en      = 1'b0;
        cap_lane    = k_q - LaneW'(1);
        Busy        = 1'b0;
        RdenData    = 1'b0;
        WrenData    = 1'b0;
        AddressData = beat_addr;
        ByteenaData = 4'hF;
        WriteData   = wr_lane;

        unique case (state_q)
            StIdle: begin
                AddressData = VecAccessM ? req_base_addr : req_word_addr;
                ByteenaData = ByteenaM;
                WriteData   = WriteDataM;
                // Write wins when both request lines are high.
                if (MemWriteM) begin
                    WrenData = 1'b1;
                    if (VecAccessM) begin
                        ByteenaData = 4'hF;
                        WriteData   = WriteDataVM[N-1:0];
                        Busy        = 1'b1;
                        addr_d      = req_base_addr;
                        wdata_d     = WriteDataVM;
                        k_d         = LaneW'(1);
                        state_d     = StVwr;
                    end
                end else if (MemReadM) begin
                    RdenData    = 1'b1;
                    ByteenaData = 4'hF;
                    Busy        = 1'b1;
                    if (VecAccessM) begin
                        addr_d  = req_base_addr;
                        k_d     = LaneW'(1);
                        state_d = StVrd;
                    end else begin
                        addr_d  = req_word_addr;
                        k_d     = '0;
                        state_d = StSrd;
                    end
                end
            end
            StSrd: begin
                Busy        = 1'b1;
                AddressData = addr_q;
                rdata_s_d   = ReadData;
                state_d     = StDone;
            end
            StVrd: begin
                Busy     = 1'b1;
                RdenData = 1'b1;
                cap_en   = 1'b1;
                k_d      = k_q + LaneW'(1);
                if (k_q == LaneW'(B - 1)) begin
                    state_d = StVrdl;
                end
            end
            StVrdl: begin
                Busy     = 1'b1;
                cap_en   = 1'b1;
                cap_lane = LaneW'(B - 1);
                k_d      = '0;
                state_d  = StDone;
            end
            StVwr: begin
                Busy     = 1'b1;
                WrenData = 1'b1;
                k_d      = k_q + LaneW'(1);
                if (k_q == LaneW'(B - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Request inputs are ignored here; the pipeline advances on this edge.
                k_d     = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // No stall and no memory traffic while reset is held.
        if (rst) begin
            Busy     = 1'b0;
            RdenData = 1'b0;
            WrenData = 1'b0;
        end
    end

    // Insert returned read data into its vector lane; other lanes keep old values.
    always_comb begin
        rdata_v_d = rdata_v_q;
        for (int i = 0; i < int'(B); i++) begin
            if (cap_en && (cap_lane == LaneW'(i))) begin
                rdata_v_d[i*N +: N] = ReadData;
            end
        end
    end

    // State and request/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_s_q <= '0;
            rdata_v_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_s_q <= rdata_s_d;
            rdata_v_q <= rdata_v_d;
        end
    end

    assign ReadDataS = rdata_s_q;
    assign ReadDataV = rdata_v_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 4 KB synchronous memory model sits on the
// memory port; expected beats, stall cycles and results come from a word-level
// reference memory updated directly from each request.
module tb_data_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         MemReadM, MemWriteM, VecAccessM;
    logic [31:0]  AddressM;
    logic [3:0]   ByteenaM;
    logic [31:0]  WriteDataM;
    logic [255:0] WriteDataVM;
    logic [31:0]  ReadDataS;
    logic [255:0] ReadDataV;
    logic         Busy;
    logic [31:0]  ReadData;
    logic [31:0]  AddressData;
    logic [3:0]   ByteenaData;
    logic [31:0]  WriteData;
    logic         RdenData;
    logic         WrenData;

    int           checks = 0;
    int           errors = 0;
    int           txn_no = 0;
    int           cyc_no = 0;

    logic         mem_clr;
    logic [31:0]  mem [1024];
    logic [31:0]  mem_w;
    logic [31:0]  exp_mem [1024];
    logic [31:0]  exp_rds;
    logic [255:0] exp_rdv;

    data_mem_responder #(.N(32), .V(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .VecAccessM  (VecAccessM),
        .AddressM    (AddressM),
        .ByteenaM    (ByteenaM),
        .WriteDataM  (WriteDataM),
        .WriteDataVM (WriteDataVM),
        .ReadDataS   (ReadDataS),
        .ReadDataV   (ReadDataV),
        .Busy        (Busy),
        .ReadData    (ReadData),
        .AddressData (AddressData),
        .ByteenaData (ByteenaData),
        .WriteData   (WriteData),
        .RdenData    (RdenData),
        .WrenData    (WrenData)
    );

    always #5 clk = ~clk;

    // Synchronous memory: byte-enabled writes, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (WrenData) begin
                mem_w = mem[AddressData[11:2]];
                for (int b = 0; b < 4; b++)
                    if (ByteenaData[b]) mem_w[8*b +: 8] = WriteData[8*b +: 8];
                mem[AddressData[11:2]] <= mem_w;
            end
            if (RdenData) ReadData <= mem[AddressData[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s txn=%0d cyc=%0d: observed %0h, expected %0h",
                   tag, txn_no, cyc_no, obs, exp);
        end
    endtask

    task automatic drive_idle();
        MemReadM    = 1'b0;
        MemWriteM   = 1'b0;
        VecAccessM  = 1'b0;
        AddressM    = '0;
        ByteenaM    = '0;
        WriteDataM  = '0;
        WriteDataVM = '0;
    endtask

    task automatic idle_cycle();
        drive_idle();
        @(negedge clk);
        chk("idle_busy", Busy, 1'b0);
        chk("idle_rden", RdenData, 1'b0);
        chk("idle_wren", WrenData, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // One request, held for its whole duration (stalled-pipeline model).
    // rst_at >= 0 asserts reset in that cycle of the access.
    task automatic txn(input logic rd, input logic wr, input logic vec, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input logic [255:0] wdv,
                       input int rst_at);
        int          nbeat, nbusy, ncyc;
        logic [31:0] base;
        logic [9:0]  widx;
        txn_no++;
        base = vec ? {addr[31:5], 5'b0} : {addr[31:2], 2'b00};
        widx = base[11:2];
        nbeat = vec ? 8 : 1;
        if (!vec) nbusy = wr ? 0 : 2;
        else      nbusy = wr ? 8 : 9;
        ncyc = (!vec && wr) ? 1 : nbusy + 1;

        if (wr) begin
            if (vec) for (int k = 0; k < 8; k++) exp_mem[widx + 10'(k)] = wdv[32*k +: 32];
            else for (int b = 0; b < 4; b++) if (be[b]) exp_mem[widx][8*b +: 8] = wd[8*b +: 8];
        end else if (vec) begin
            for (int k = 0; k < 8; k++) exp_rdv[32*k +: 32] = exp_mem[widx + 10'(k)];
        end else begin
            exp_rds = exp_mem[widx];
        end

        MemReadM    = rd;
        MemWriteM   = wr;
        VecAccessM  = vec;
        AddressM    = addr;
        ByteenaM    = be;
        WriteDataM  = wd;
        WriteDataVM = wdv;

        for (int c = 0; c < ncyc; c++) begin
            cyc_no = c;
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            if (c == rst_at) begin
                chk("rst_busy", Busy, 1'b0);
                chk("rst_rden", RdenData, 1'b0);
                chk("rst_wren", WrenData, 1'b0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                drive_idle();
                exp_rds = '0;
                exp_rdv = '0;
                @(negedge clk);
                chk("post_rst_busy", Busy, 1'b0);
                chk("post_rst_rden", RdenData, 1'b0);
                chk("post_rst_wren", WrenData, 1'b0);
                chk("post_rst_rdv", ReadDataV, exp_rdv);
                chk("post_rst_rds", ReadDataS, exp_rds);
                @(posedge clk);
                #1;
                return;
            end
            chk("busy", Busy, c < nbusy);
            chk("wren", WrenData, wr && (c < nbeat));
            chk("rden", RdenData, !wr && (c < nbeat));
            if (c < nbeat) begin
                chk("addr", AddressData, base + 32'(4 * c));
                chk("byteena", ByteenaData, (wr && !vec) ? be : 4'hF);
                if (wr) chk("wdata", WriteData, vec ? wdv[32*c +: 32] : wd);
            end
            if (c == ncyc - 1) begin
                chk("rds", ReadDataS, exp_rds);
                chk("rdv", ReadDataV, exp_rdv);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [255:0] v;
        logic [2:0]   sel;

        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        exp_rds = '0;
        exp_rdv = '0;

        // Reset with a request present: no stall and no strobes.
        rst     = 1'b1;
        mem_clr = 1'b1;
        drive_idle();
        MemReadM   = 1'b1;
        VecAccessM = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_rden", RdenData, 1'b0);
        chk("reset_wren", WrenData, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_clr = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("reset_rds", ReadDataS, 32'h0);
        chk("reset_rdv", ReadDataV, 256'h0);
        chk("reset_idle_busy", Busy, 1'b0);
        @(posedge clk);
        #1;

        // Scalar store then partial-word load.
        txn(1'b0, 1'b1, 1'b0, 32'h0000_0104, 4'b0011, 32'hDEAD_BEEF, '0, -1);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0106, 4'h0, '0, '0, -1);
        chk("scalar_beef", ReadDataS, 32'h0000_BEEF);

        // Vector store at an unaligned address.
        for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'h1000_0000 + 32'(k);
        txn(1'b0, 1'b1, 1'b1, 32'h0000_0047, 4'h0, '0, v, -1);

        // Vector load of 0xA0+k words.
        for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'hA0 + 32'(k);
        txn(1'b0, 1'b1, 1'b1, 32'h0000_0040, 4'h0, '0, v, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, 4'h0, '0, '0, -1);
        chk("vec_a0", ReadDataV, v);
        idle_cycle();

        // Read and write together: the write wins.
        txn(1'b1, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h1234_5678, '0, -1);
        idle_cycle();

        // Reset at vector-load beat 4, then a scalar load.
        txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, 4'h0, '0, '0, 4);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0010, 4'h0, '0, '0, -1);

        // Randomized back-to-back traffic.
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
            sel = 3'($urandom_range(0, 4));
            txn(sel == 3'd0 || sel == 3'd3, sel != 3'd0, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 4095)), 4'($urandom), $urandom, v, -1);
            if (sel == 3'd4) idle_cycle();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
